// File: rtl/uart_echo_if.sv
// FIFO-side handshake bundle for uart_echo_engine: rx FIFO head/pop and
// tx FIFO full/push. The engine uses the slave modport, and the FIFO side
// uses the master modport.
interface uart_echo_if #(
  parameter int DATA_W = 8
);
  logic              i_rx_empty;
  logic [DATA_W-1:0] i_rd_data;
  logic [2:0]        i_err;
  logic              o_rd_uart;
  logic              i_tx_full;
  logic              o_wr_uart;
  logic [DATA_W-1:0] o_wr_data;

  modport slave (
    input  i_rx_empty, i_rd_data, i_err, i_tx_full,
    output o_rd_uart, o_wr_uart, o_wr_data
  );

  modport master (
    output i_rx_empty, i_rd_data, i_err, i_tx_full,
    input  o_rd_uart, o_wr_uart, o_wr_data
  );
endinterface

// File: rtl/uart_echo_engine.sv
// uart_echo_engine: pops words from the uart rx FIFO, transforms them
// (pass / add INC / invert / bit-reverse) and pushes the result to the tx FIFO.
// It also keeps rx, tx and error statistics.
// Optional macro UART_ECHO_DROP_ERR_EN: when it is defined, words that arrive
// with error flags are counted and then discarded instead of being echoed.
//
// state | meaning
// IDLE  | waiting for i_en and a non-empty rx FIFO
// XFORM | pop strobe high, transform computed into result register
// SEND  | waiting for tx FIFO space, then push
// DONE  | push strobe high, return to IDLE (lets the pop settle)
module uart_echo_engine #(
  parameter int DATA_W = 8,
  parameter int INC    = 1,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic [1:0]        i_mode,
  input  logic              i_clr,
  uart_echo_if.slave        fifo,
  output logic [DATA_W-1:0] o_last_rx,
  output logic [DATA_W-1:0] o_last_tx,
  output logic [CNT_W-1:0]  o_rx_cnt,
  output logic [CNT_W-1:0]  o_tx_cnt,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFORM = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] result_q;
  logic [1:0]        mode_q;
`ifdef UART_ECHO_DROP_ERR_EN
  logic              err_q;
`endif

  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d,
                                              input logic [1:0]        m);
    logic [DATA_W-1:0] r;
    r = d;
    case (m)
      2'b00: r = d;
      2'b01: r = d + DATA_W'(INC);
      2'b10: r = ~d;
      default: begin
        for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
      end
    endcase
    return r;
  endfunction

  // Sequencing FSM with all outputs registered; i_clr overrides counter updates.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      data_q         <= '0;
      result_q       <= '0;
      mode_q         <= '0;
`ifdef UART_ECHO_DROP_ERR_EN
      err_q          <= 1'b0;
`endif
      fifo.o_rd_uart <= 1'b0;
      fifo.o_wr_uart <= 1'b0;
      fifo.o_wr_data <= '0;
      o_last_rx      <= '0;
      o_last_tx      <= '0;
      o_rx_cnt       <= '0;
      o_tx_cnt       <= '0;
      o_err_cnt      <= '0;
      o_busy         <= 1'b0;
    end else begin
      fifo.o_rd_uart <= 1'b0;
      fifo.o_wr_uart <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en && !fifo.i_rx_empty) begin
            data_q         <= fifo.i_rd_data;
            o_last_rx      <= fifo.i_rd_data;
            mode_q         <= i_mode;
`ifdef UART_ECHO_DROP_ERR_EN
            err_q          <= (fifo.i_err != 3'b000);
`endif
            fifo.o_rd_uart <= 1'b1;
            o_rx_cnt       <= o_rx_cnt + CNT_W'(1);
            if (fifo.i_err != 3'b000) o_err_cnt <= o_err_cnt + CNT_W'(1);
            o_busy         <= 1'b1;
            state          <= XFORM;
          end
        end
        XFORM: begin
          result_q <= xform(data_q, mode_q);
`ifdef UART_ECHO_DROP_ERR_EN
          if (err_q) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            state  <= SEND;
          end
`else
          state    <= SEND;
`endif
        end
        SEND: begin
          if (!fifo.i_tx_full) begin
            fifo.o_wr_data <= result_q;
            fifo.o_wr_uart <= 1'b1;
            o_last_tx      <= result_q;
            o_tx_cnt       <= o_tx_cnt + CNT_W'(1);
            state          <= DONE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
      if (i_clr) begin
        o_rx_cnt  <= '0;
        o_tx_cnt  <= '0;
        o_err_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_engine.sv
// Self-checking bench for uart_echo_engine: directed vector table, corner
// sequences and random traffic against a queue-based reference model.
// Two instances run side by side, one with 16-bit counters and one with 4-bit counters.
module tb_uart_echo_engine;
  localparam int DW  = 8;
  localparam int INC = 1;
`ifdef UART_ECHO_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, en, clr, rx_empty, tx_full;
  logic [1:0]    mode;
  logic [DW-1:0] rd_data;
  logic [2:0]    err;

  uart_echo_if #(.DATA_W(DW)) bus_a ();
  uart_echo_if #(.DATA_W(DW)) bus_b ();
  assign bus_a.i_rx_empty = rx_empty;
  assign bus_a.i_rd_data  = rd_data;
  assign bus_a.i_err      = err;
  assign bus_a.i_tx_full  = tx_full;
  assign bus_b.i_rx_empty = rx_empty;
  assign bus_b.i_rd_data  = rd_data;
  assign bus_b.i_err      = err;
  assign bus_b.i_tx_full  = tx_full;

  logic [DW-1:0] last_rx_a, last_tx_a, last_rx_b, last_tx_b;
  logic [15:0]   rx_cnt_a, tx_cnt_a, err_cnt_a;
  logic [3:0]    rx_cnt_b, tx_cnt_b, err_cnt_b;
  logic          busy_a, busy_b;

  uart_echo_engine #(.DATA_W(DW), .INC(INC), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_mode(mode), .i_clr(clr),
    .fifo(bus_a), .o_last_rx(last_rx_a), .o_last_tx(last_tx_a),
    .o_rx_cnt(rx_cnt_a), .o_tx_cnt(tx_cnt_a), .o_err_cnt(err_cnt_a), .o_busy(busy_a));

  uart_echo_engine #(.DATA_W(DW), .INC(INC), .CNT_W(4)) dut_b (
    .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_mode(mode), .i_clr(clr),
    .fifo(bus_b), .o_last_rx(last_rx_b), .o_last_tx(last_tx_b),
    .o_rx_cnt(rx_cnt_b), .o_tx_cnt(tx_cnt_b), .o_err_cnt(err_cnt_b), .o_busy(busy_b));

  typedef struct { int data; int err; } word_t;
  typedef struct { logic [1:0] mode; int data; int expv; } vec_t;

  word_t rx_q[$];
  int    exp_q[$];
  int    exp_rx, exp_tx, exp_err;
  int    errors = 0;
  int    checks = 0;
  bit    seen_rd, seen_wr;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Written straight from the transform definitions, using arithmetic.
  function automatic int model_f(input int d, input int m);
    int r;
    case (m)
      0: r = d;
      1: r = (d + INC) % 256;
      2: r = 255 - d;
      default: begin
        r = 0;
        for (int i = 0; i < 8; i++)
          if (((d >> i) & 1) == 1) r += (1 << (7 - i));
      end
    endcase
    return r;
  endfunction

  task automatic upd_rx();
    if (rx_q.size() == 0) begin
      rx_empty = 1'b1; rd_data = '0; err = '0;
    end else begin
      rx_empty = 1'b0; rd_data = 8'(rx_q[0].data); err = 3'(rx_q[0].err);
    end
  endtask

  task automatic push_word(input int d, input int e);
    word_t w;
    w.data = d; w.err = e;
    rx_q.push_back(w);
    upd_rx();
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rx = 0; exp_tx = 0; exp_err = 0;
  endtask

  // One clock cycle: sample at the falling edge, then run the FIFO model and the scoreboard.
  task automatic tick();
    word_t w;
    int    e;
    @(negedge clk);
    seen_rd = bus_a.o_rd_uart;
    seen_wr = bus_a.o_wr_uart;
    chk("strobe_overlap", int'(seen_rd && seen_wr), 0);
    if (seen_rd) begin
      chk("pop_has_data", int'(rx_q.size() > 0), 1);
      if (rx_q.size() > 0) begin
        w = rx_q.pop_front();
        chk("last_rx", int'(last_rx_a), w.data);
        exp_rx++;
        if (w.err != 0) exp_err++;
        if (!(DROP && w.err != 0)) exp_q.push_back(model_f(w.data, int'(mode)));
        upd_rx();
      end
    end
    if (seen_wr) begin
      chk("push_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_data", int'(bus_a.o_wr_data), e);
        chk("last_tx", int'(last_tx_a), e);
        exp_tx++;
      end
    end
    if (clr) begin exp_rx = 0; exp_tx = 0; exp_err = 0; end
    chk("rx_cnt16", int'(rx_cnt_a), exp_rx % 65536);
    chk("tx_cnt16", int'(tx_cnt_a), exp_tx % 65536);
    chk("err_cnt16", int'(err_cnt_a), exp_err % 65536);
    chk("rx_cnt4", int'(rx_cnt_b), exp_rx % 16);
    chk("tx_cnt4", int'(tx_cnt_b), exp_tx % 16);
    chk("err_cnt4", int'(err_cnt_b), exp_err % 16);
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (rx_q.size() == 0 && exp_q.size() == 0 && !busy_a) break;
      tick();
    end
    chk("drain_done", int'(rx_q.size() == 0 && exp_q.size() == 0 && !busy_a), 1);
  endtask

  task automatic wait_rd(input int max);
    seen_rd = 1'b0;
    for (int i = 0; i < max && !seen_rd; i++) tick();
    chk("wait_rd", int'(seen_rd), 1);
  endtask

  vec_t vecs[8];
  int   rd_t, wr_t, pushes;

  initial begin
    vecs[0] = '{2'b01, 'h41, 'h42};
    vecs[1] = '{2'b10, 'h0F, 'hF0};
    vecs[2] = '{2'b11, 'h0F, 'hF0};
    vecs[3] = '{2'b11, 'h01, 'h80};
    vecs[4] = '{2'b01, 'hFF, 'h00};
    vecs[5] = '{2'b00, 'h55, 'h55};
    vecs[6] = '{2'b10, 'hA5, 'h5A};
    vecs[7] = '{2'b11, 'h12, 'h48};

    reset_n = 1'b0; en = 1'b0; clr = 1'b0; mode = 2'b00; tx_full = 1'b0;
    upd_rx();
    model_reset();
    #1;
    chk("rst_rd_uart", int'(bus_a.o_rd_uart), 0);
    chk("rst_wr_uart", int'(bus_a.o_wr_uart), 0);
    chk("rst_wr_data", int'(bus_a.o_wr_data), 0);
    chk("rst_last_rx", int'(last_rx_a), 0);
    chk("rst_last_tx", int'(last_tx_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    repeat (2) tick();
    reset_n = 1'b1;
    en = 1'b1;

    // Directed transform vectors, including the latency check
    foreach (vecs[k]) begin
      mode = vecs[k].mode;
      push_word(vecs[k].data, 0);
      rd_t = -10; wr_t = -1;
      for (int c = 0; c < 20 && wr_t < 0; c++) begin
        tick();
        if (seen_rd) rd_t = c;
        if (seen_wr) begin
          wr_t = c;
          chk("vec_wr_data", int'(bus_a.o_wr_data), vecs[k].expv);
        end
      end
      chk("vec_latency", wr_t - rd_t, 2);
      drain(10);
    end

    // Tx full held for 10 cycles; the mode change after capture must not matter
    tx_full = 1'b1; mode = 2'b00;
    push_word('h55, 0);
    wait_rd(10);
    mode = 2'b11;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_no_push", int'(bus_a.o_wr_uart), 0);
      chk("hold_busy", int'(busy_a), 1);
    end
    tx_full = 1'b0;
    tick();
    chk("hold_release_push", int'(bus_a.o_wr_uart), 1);
    chk("hold_release_data", int'(bus_a.o_wr_data), 'h55);
    drain(10);

    // Error word in the middle of three queued words
    clr = 1'b1; tick(); clr = 1'b0;
    mode = 2'b01;
    push_word('h10, 0); push_word('h20, 4); push_word('h30, 0);
    drain(40);
    chk("err_err_cnt", int'(err_cnt_a), 1);
    chk("err_rx_cnt", int'(rx_cnt_a), 3);
    chk("err_tx_cnt", int'(tx_cnt_a), DROP ? 2 : 3);

    // Counter wrap in the 4-bit instance after 16 bytes
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < 16; i++) push_word($urandom_range(0, 255), 0);
    drain(120);
    chk("wrap_rx_cnt4", int'(rx_cnt_b), 0);
    chk("wrap_rx_cnt16", int'(rx_cnt_a), 16);

    // Clear in the same cycle as a capture takes priority
    push_word('h77, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_cap_seen", int'(seen_rd), 1);
    chk("clr_cap_rx", int'(rx_cnt_a), 0);
    chk("clr_cap_err", int'(err_cnt_a), 0);
    chk("clr_cap_tx", int'(tx_cnt_a), 0);
    chk("clr_cap_last_rx", int'(last_rx_a), 'h77);
    drain(10);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      mode    = 2'($urandom_range(0, 3));
      en      = ($urandom_range(0, 9) != 0);
      tx_full = ($urandom_range(0, 3) == 0);
      if (rx_q.size() < 4 && $urandom_range(0, 2) == 0)
        push_word($urandom_range(0, 255),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
      tick();
    end
    en = 1'b1; tx_full = 1'b0;
    drain(200);

    // Reset while waiting in SEND
    tx_full = 1'b1;
    push_word('h33, 0);
    wait_rd(10);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_wr_uart", int'(bus_a.o_wr_uart), 0);
    chk("arst_rx_cnt", int'(rx_cnt_a), 0);
    chk("arst_tx_cnt", int'(tx_cnt_a), 0);
    chk("arst_err_cnt", int'(err_cnt_a), 0);
    chk("arst_busy", int'(busy_a), 0);
    chk("arst_last_rx", int'(last_rx_a), 0);
    model_reset();
    tick();
    reset_n = 1'b1;
    tx_full = 1'b0;
    pushes = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (seen_wr) pushes++;
    end
    chk("arst_no_push", pushes, 0);

    // Pop strobe must fall as soon as reset is asserted
    push_word('h44, 0);
    wait_rd(10);
    #1 reset_n = 1'b0;
    #1 chk("arst_rd_strobe", int'(bus_a.o_rd_uart), 0);
    model_reset();
    tick();
    reset_n = 1'b1;

    // Push strobe must fall as soon as reset is asserted
    push_word('h45, 0);
    seen_wr = 1'b0;
    for (int c = 0; c < 20 && !seen_wr; c++) tick();
    chk("wr_strobe_seen", int'(seen_wr), 1);
    #1 reset_n = 1'b0;
    #1 chk("arst_wr_strobe", int'(bus_a.o_wr_uart), 0);
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
